unidade_controle_exp5: RTL and testbench

//  Control unit (Moore FSM) for the sequence-memory game datapath: address counter,
//  ROM of 16 expected plays, play register, comparator and play edge detector.

---
 rtl/unidade_controle_exp5.sv | 101 ++++++++++
 tb/tb_unidade_controle_exp5.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_exp5.sv
// unidade_controle_exp5: Moore control FSM for the sequence-memory game.
// Sequences one game of up to 16 plays, ending in hit, miss or per-play timeout.
module unidade_controle_exp5 #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_TEMPO  = 4'hD,
        FIM_ERRO   = 4'hE
    } estado_t;

    localparam int TW = TIMEOUT_CICLOS > 0 ? $clog2(TIMEOUT_CICLOS + 1) : 1;
    localparam int LIMITE = TIMEOUT_CICLOS > 0 ? TIMEOUT_CICLOS - 1 : 0;

    estado_t estado, estado_prox;
    logic [TW-1:0] timer;
    logic expirou;

    assign expirou = (TIMEOUT_CICLOS != 0) && (timer == TW'(LIMITE));

    // Timer only runs while we stay in ESPERA, so it restarts on every entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= INICIAL;
            timer  <= '0;
        end else begin
            estado <= estado_prox;
            timer  <= (estado == ESPERA && estado_prox == ESPERA) ? timer + 1'b1 : '0;
        end
    end

    always_comb begin
        estado_prox = INICIAL;
        zeraC       = 1'b0;
        contaC      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        db_estado   = estado;
        case (estado)
            INICIAL:    estado_prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: begin
                estado_prox = ESPERA;
                zeraC       = 1'b1;
                zeraR       = 1'b1;
            end
            ESPERA:     estado_prox = jogada ? REGISTRA : expirou ? FIM_TEMPO : ESPERA;
            REGISTRA: begin
                estado_prox = COMPARACAO;
                registraR   = 1'b1;
            end
            COMPARACAO: estado_prox = !igual ? FIM_ERRO : fimC ? FIM_ACERTO : PROXIMO;
            PROXIMO: begin
                estado_prox = ESPERA;
                contaC      = 1'b1;
            end
            FIM_ACERTO: begin
                estado_prox = iniciar ? PREPARACAO : FIM_ACERTO;
                pronto      = 1'b1;
                acertou     = 1'b1;
            end
            FIM_ERRO: begin
                estado_prox = iniciar ? PREPARACAO : FIM_ERRO;
                pronto      = 1'b1;
                errou       = 1'b1;
            end
            FIM_TEMPO: begin
                estado_prox = iniciar ? PREPARACAO : FIM_TEMPO;
                pronto      = 1'b1;
                errou       = 1'b1;
                timeout     = 1'b1;
            end
            default:    estado_prox = INICIAL;
        endcase
    end
endmodule

// File: tb/tb_unidade_controle_exp5.sv
// tb_unidade_controle_exp5: table-driven vectors plus hand sequences for
// full game, timeout boundary and reset corner cases.
module tb_unidade_controle_exp5;
    logic clock = 1'b0;
    logic reset = 1'b0, iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimC = 1'b0;
    logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0, errors = 0;
    int n_conta = 0, n_registra = 0, n_zera = 0;

    typedef struct {
        logic       rst, ini, jog, ig, fim;
        logic [3:0] st;
    } vec_t;
    vec_t vs[$];

    unidade_controle_exp5 #(.TIMEOUT_CICLOS(20)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        n_conta    += int'(contaC);
        n_registra += int'(registraR);
        n_zera     += int'(zeraC);
    end

    // Expected {state, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [11:0] expo(input logic [3:0] s);
        logic [7:0] f;
        case (s)
            4'h1:    f = 8'b1010_0000;
            4'h4:    f = 8'b0001_0000;
            4'h6:    f = 8'b0100_0000;
            4'hA:    f = 8'b0000_1100;
            4'hE:    f = 8'b0000_1010;
            4'hD:    f = 8'b0000_1011;
            default: f = 8'b0000_0000;
        endcase
        return {s, f};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] s);
        logic [11:0] got;
        got = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        checks++;
        if (got !== expo(s)) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, expo(s));
        end
    endtask

    task automatic chk_n(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic r, i, j, g, f, input logic [3:0] s);
        vec_t v;
        v.rst = r; v.ini = i; v.jog = j; v.ig = g; v.fim = f; v.st = s;
        vs.push_back(v);
    endtask

    task automatic start_game(input string name);
        iniciar = 1'b1; tick(); chk({name, "_prep"}, 4'h1);
        iniciar = 1'b0; tick(); chk({name, "_espera"}, 4'h2);
    endtask

    initial begin
        int idx_e;
        // Reset, then iniciar held 5 cycles
        push(0, 0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 5; k++) push(1, 1, 0, 0, 0, k == 0 ? 4'h1 : 4'h2);
        // Three correct plays, fourth wrong
        for (int k = 0; k < 3; k++) begin
            push(1, 0, 1, 0, 0, 4'h4);
            push(1, 0, 0, 0, 0, 4'h5);
            push(1, 0, 0, 1, 0, 4'h6);
            push(1, 0, 0, 0, 0, 4'h2);
        end
        push(1, 0, 1, 0, 0, 4'h4);
        push(1, 0, 0, 0, 0, 4'h5);
        push(1, 0, 0, 0, 0, 4'hE);
        idx_e = vs.size() - 1;
        push(1, 0, 1, 1, 0, 4'hE);
        push(1, 1, 0, 0, 0, 4'h1);
        push(1, 0, 0, 0, 0, 4'h2);
        // Reset while in COMPARACAO, then jogada ignored in INICIAL
        push(1, 0, 1, 0, 0, 4'h4);
        push(1, 0, 0, 0, 0, 4'h5);
        push(0, 0, 0, 1, 1, 4'h0);
        push(1, 0, 1, 0, 0, 4'h0);
        push(1, 0, 0, 0, 0, 4'h0);

        #2;
        foreach (vs[i]) begin
            reset = vs[i].rst; iniciar = vs[i].ini; jogada = vs[i].jog;
            igual = vs[i].ig;  fimC = vs[i].fim;
            tick();
            chk($sformatf("vec%0d", i), vs[i].st);
            if (i == 5) begin
                chk_n("zeraC_pulses_start", n_zera, 1);
                n_conta = 0;
            end
            if (i == idx_e) chk_n("contaC_before_erro", n_conta, 3);
        end
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;

        // Full 16-play winning game
        n_conta = 0; n_registra = 0; n_zera = 0;
        start_game("win");
        for (int p = 0; p < 16; p++) begin
            repeat (p % 3) tick();
            jogada = 1'b1; tick(); chk("win_reg", 4'h4);
            jogada = 1'b0; tick(); chk("win_cmp", 4'h5);
            igual = 1'b1; fimC = (p == 15); tick();
            chk("win_next", p == 15 ? 4'hA : 4'h6);
            igual = 1'b0; fimC = 1'b0;
            if (p < 15) begin tick(); chk("win_back", 4'h2); end
        end
        chk_n("win_contaC", n_conta, 15);
        chk_n("win_registraR", n_registra, 16);
        chk_n("win_zeraC", n_zera, 1);
        jogada = 1'b1; tick(); jogada = 1'b0; chk("jogada_in_fim_acerto", 4'hA);

        // Timeout after exactly 20 cycles in ESPERA
        start_game("to");
        for (int k = 0; k < 19; k++) begin tick(); chk("to_wait", 4'h2); end
        tick(); chk("to_fim_tempo", 4'hD);
        tick(); chk("to_hold", 4'hD);

        // jogada on the last timer value wins over timeout
        start_game("late");
        repeat (19) tick();
        chk("late_still_espera", 4'h2);
        jogada = 1'b1; tick(); chk("late_reg", 4'h4);
        jogada = 1'b0; tick(); chk("late_cmp", 4'h5);
        tick(); chk("late_erro", 4'hE);

        // Reset in ESPERA with timer at 10 clears timer
        start_game("rst");
        repeat (10) tick();
        reset = 1'b0; tick(); chk("rst_espera", 4'h0);
        reset = 1'b1;
        start_game("rst2");
        for (int k = 0; k < 19; k++) begin tick(); chk("rst2_wait", 4'h2); end
        tick(); chk("rst2_fim_tempo", 4'hD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
